// File: rtl/mac_cfg_loader.sv
// Configuration front-end for mac_cluster: assembles an LSB-first chunk stream into
// the cluster cfg word, applies it with a cset pulse and gates the cluster enable.
module mac_cfg_loader #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
  parameter int IN_WIDTH       = 8,
  parameter int CSET_CYCLES    = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [IN_WIDTH-1:0]                       in_data,
  input  logic                                      in_last,
  output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] cfg,
  output logic                                      cset,
  output logic                                      mac_en,
  output logic                                      loaded,
  output logic                                      frame_err,
  output logic [1:0]                                state_dbg
);

  localparam int CFG_WIDTH  = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;
  localparam int NUM_CHUNKS = (CFG_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int SHADOW_W   = NUM_CHUNKS * IN_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CC_W       = (CSET_CYCLES > 1) ? $clog2(CSET_CYCLES) : 1;

  // Handshake: a chunk transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on state, and in_data/in_last are ignored otherwise.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    APPLY = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CC_W-1:0]        cset_cnt_q, cset_cnt_d;
  logic [SHADOW_W-1:0]    shadow_q, shadow_d;
  logic [CFG_WIDTH-1:0]   cfg_d;
  logic                   cset_d, mac_en_d, loaded_d, frame_err_d;
  logic [CNT_W-1:0]       wr_idx;
  logic                   accept, is_final;

  assign in_ready  = (state_q != APPLY);
  assign state_dbg = state_q;
  assign accept    = in_valid && in_ready;
  // A chunk accepted while running always starts a fresh word at index 0.
  assign wr_idx    = (state_q == RUN) ? '0 : count_q;
  assign is_final  = (wr_idx == CNT_W'(NUM_CHUNKS - 1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cset_cnt_d  = cset_cnt_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg;
    cset_d      = 1'b0;
    mac_en_d    = mac_en;
    loaded_d    = loaded;
    frame_err_d = 1'b0;
    case (state_q)
      LOAD, RUN: begin
        if (accept) begin
          mac_en_d = 1'b0;
          loaded_d = 1'b0;
          state_d  = LOAD;
          shadow_d[int'(wr_idx) * IN_WIDTH +: IN_WIDTH] = in_data;
          if (in_last && is_final) begin
            cfg_d      = shadow_d[CFG_WIDTH-1:0];
            cset_d     = 1'b1;
            count_d    = '0;
            cset_cnt_d = '0;
            state_d    = APPLY;
          end else if (in_last || is_final) begin
            frame_err_d = 1'b1;
            count_d     = '0;
          end else begin
            count_d = wr_idx + CNT_W'(1);
          end
        end
      end
      APPLY: begin
        if (cset_cnt_q == CC_W'(CSET_CYCLES - 1)) begin
          mac_en_d = 1'b1;
          loaded_d = 1'b1;
          state_d  = RUN;
        end else begin
          cset_d     = 1'b1;
          cset_cnt_d = cset_cnt_q + CC_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LOAD;
      count_q    <= '0;
      cset_cnt_q <= '0;
      shadow_q   <= '0;
      cfg        <= '0;
      cset       <= 1'b0;
      mac_en     <= 1'b0;
      loaded     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cset_cnt_q <= cset_cnt_d;
      shadow_q   <= shadow_d;
      cfg        <= cfg_d;
      cset       <= cset_d;
      mac_en     <= mac_en_d;
      loaded     <= loaded_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Bench for mac_cfg_loader: two instances (CSET_CYCLES 1 and 3) share one stream and
// are checked every cycle against a chunk-queue reference model.
module tb_mac_cfg_loader;

  localparam int CW  = 132;
  localparam int NCH = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;

  logic          in_ready_a, cset_a, mac_en_a, loaded_a, frame_err_a;
  logic          in_ready_b, cset_b, mac_en_b, loaded_b, frame_err_b;
  logic [CW-1:0] cfg_a, cfg_b;
  logic [1:0]    state_dbg_a, state_dbg_b;

  always #5 clk = ~clk;

  mac_cfg_loader u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .cfg(cfg_a), .cset(cset_a),
    .mac_en(mac_en_a), .loaded(loaded_a), .frame_err(frame_err_a),
    .state_dbg(state_dbg_a)
  );

  mac_cfg_loader #(.CSET_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .cfg(cfg_b), .cset(cset_b),
    .mac_en(mac_en_b), .loaded(loaded_b), .frame_err(frame_err_b),
    .state_dbg(state_dbg_b)
  );

  // ---------------- reference model ----------------
  // Received chunks are queued; a word is judged only when it ends (in_last) or
  // overruns. Each instance counts down its remaining cset cycles.
  logic [7:0]    m_chunks[$];
  logic [CW-1:0] m_cfg[2];
  logic          m_cset[2], m_en[2], m_loaded[2], m_ferr[2];
  int            m_left[2];
  int            m_cset_len[2] = '{1, 3};
  logic [NCH*8-1:0] m_word;
  logic          m_acc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cfg[i] = '0; m_cset[i] = 0; m_en[i] = 0; m_loaded[i] = 0; m_ferr[i] = 0; m_left[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_cfg[i] = '0; m_cset[i] = 0; m_en[i] = 0; m_loaded[i] = 0; m_ferr[i] = 0; m_left[i] = 0;
      end
      m_chunks.delete();
    end else begin
      m_acc = in_valid && (m_left[0] == 0) && (m_left[1] == 0);
      for (int i = 0; i < 2; i++) begin
        m_ferr[i] = 0;
        if (m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_cset[i] = 0; m_en[i] = 1; m_loaded[i] = 1;
          end
        end
      end
      if (m_acc) begin
        for (int i = 0; i < 2; i++) begin
          m_en[i] = 0; m_loaded[i] = 0;
        end
        m_chunks.push_back(in_data);
        if (in_last && m_chunks.size() == NCH) begin
          m_word = '0;
          for (int k = 0; k < NCH; k++) m_word[k*8 +: 8] = m_chunks[k];
          for (int i = 0; i < 2; i++) begin
            m_cfg[i] = m_word[CW-1:0]; m_cset[i] = 1; m_left[i] = m_cset_len[i];
          end
          m_chunks.delete();
        end else if (in_last || m_chunks.size() == NCH) begin
          for (int i = 0; i < 2; i++) m_ferr[i] = 1;
          m_chunks.delete();
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_cset_a = 0, n_cset_b = 0, n_ferr_a = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("cfg_a", cfg_a, m_cfg[0]);
    chk("cset_a", CW'(cset_a), CW'(m_cset[0]));
    chk("mac_en_a", CW'(mac_en_a), CW'(m_en[0]));
    chk("loaded_a", CW'(loaded_a), CW'(m_loaded[0]));
    chk("frame_err_a", CW'(frame_err_a), CW'(m_ferr[0]));
    chk("in_ready_a", CW'(in_ready_a), CW'(m_left[0] == 0));
    chk("cfg_b", cfg_b, m_cfg[1]);
    chk("cset_b", CW'(cset_b), CW'(m_cset[1]));
    chk("mac_en_b", CW'(mac_en_b), CW'(m_en[1]));
    chk("loaded_b", CW'(loaded_b), CW'(m_loaded[1]));
    chk("frame_err_b", CW'(frame_err_b), CW'(m_ferr[1]));
    chk("in_ready_b", CW'(in_ready_b), CW'(m_left[1] == 0));
    if (cset_a) n_cset_a++;
    if (cset_b) n_cset_b++;
    if (frame_err_a) n_ferr_a++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  logic [7:0] word_q[$];

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    sample();
    advance();
  endtask

  task automatic send_chunk(input logic [7:0] d, input logic l, input bit gap);
    int guard = 0;
    while (!(m_left[0] == 0 && m_left[1] == 0)) begin
      idle();
      guard++;
      if (guard > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout waited=%0d limit=50", guard);
        break;
      end
    end
    if (gap) idle();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    sample();
    advance();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_word(input bit gap);
    for (int k = 0; k < word_q.size(); k++)
      send_chunk(word_q[k], k == word_q.size() - 1, gap);
  endtask

  task automatic make_random_word();
    word_q.delete();
    for (int k = 0; k < NCH; k++) word_q.push_back(8'($urandom));
  endtask

  logic [CW-1:0] exp_lit, ones, zero_w;
  int            c0a, c0b, f0;

  initial begin
    exp_lit = {32'd4, 32'd3, 32'd2, 32'd1, 4'd5};
    ones    = '1;
    zero_w  = '0;
    reset   = 1'b0;
    advance();
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    chk("pin_reset_cfg", cfg_a, zero_w);
    chk("pin_reset_en", CW'(mac_en_a), CW'(0));
    reset = 1'b1;
    idle();

    // Known-value load, back-to-back then with in_valid toggled.
    for (int pass = 0; pass < 2; pass++) begin
      word_q.delete();
      for (int k = 0; k < NCH; k++) word_q.push_back(8'h00);
      word_q[0] = 8'h15; word_q[4] = 8'h20; word_q[8] = 8'h30; word_q[12] = 8'h40;
      c0a = n_cset_a; c0b = n_cset_b;
      send_word(pass == 1);
      sample();
      chk("pin_cset_lat", CW'(cset_a), CW'(1));
      chk("pin_cfg_at_cset", cfg_a, exp_lit);
      advance();
      sample();
      chk("pin_en_after", CW'(mac_en_a), CW'(1));
      chk("pin_loaded_after", CW'(loaded_a), CW'(1));
      advance();
      for (int i = 0; i < 4; i++) idle();
      chk("pin_cset_a_len", CW'(n_cset_a - c0a), CW'(1));
      chk("pin_cset_b_len", CW'(n_cset_b - c0b), CW'(3));
      chk("pin_cfg_b", cfg_b, exp_lit);
    end

    // Early in_last: framing error, cfg held, then an all-ones word.
    f0 = n_ferr_a;
    for (int k = 0; k <= 5; k++) send_chunk(8'hA5, k == 5, 1'b0);
    for (int i = 0; i < 3; i++) idle();
    chk("pin_ferr_cnt", CW'(n_ferr_a - f0), CW'(1));
    chk("pin_cfg_hold", cfg_a, exp_lit);
    word_q.delete();
    for (int k = 0; k < NCH; k++) word_q.push_back(8'hFF);
    send_word(1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("pin_ones", cfg_a, ones);

    // New load while running: enable drops after first accept, old cfg held.
    make_random_word();
    send_chunk(word_q[0], 1'b0, 1'b0);
    sample();
    chk("pin_run_en_drop", CW'(mac_en_a), CW'(0));
    chk("pin_run_cfg_hold", cfg_a, ones);
    advance();
    for (int k = 1; k < NCH; k++) send_chunk(word_q[k], k == NCH - 1, 1'b0);
    for (int i = 0; i < 4; i++) idle();

    // Reset in the middle of a load, then a clean load.
    make_random_word();
    for (int k = 0; k < 10; k++) send_chunk(word_q[k], 1'b0, 1'b0);
    reset = 1'b0;
    idle(); idle();
    chk("pin_midreset_cfg", cfg_a, zero_w);
    reset = 1'b1;
    idle();
    make_random_word();
    send_word(1'b1);
    for (int i = 0; i < 4; i++) idle();

    // Random framing: mixed lengths, missing/early in_last, random gaps.
    for (int it = 0; it < 40; it++) begin
      int len;
      bit has_last;
      len = $urandom_range(1, NCH + 1);
      if ($urandom_range(0, 2) != 0) len = NCH;
      has_last = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < len; k++)
        send_chunk(8'($urandom), has_last && (k == len - 1), $urandom_range(0, 3) == 0);
      for (int i = 0; i < $urandom_range(0, 5); i++) idle();
    end
    for (int i = 0; i < 6; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_cfg_loader.md
Name: mac_cfg_loader

Overview:
Configuration front-end for mac_cluster. It accepts the cluster's configuration word as a stream of narrow chunks over a valid/ready interface and assembles them, LSB-first, into a shadow register. On a complete, well-framed load it drives the assembled word onto the cluster's `cfg` bus and pulses `cset`. It gates the cluster's `en` low while a load or apply is in progress. Together with mac_cluster it replaces the wide parallel cfg/cset drive used in simulation.

Parameters:
- MAC_CONF_WIDTH, 4, mode-select field width (cfg[MAC_CONF_WIDTH-1:0])
- MAC_MIN_WIDTH, 8, minimum operand width (passed through for consistency)
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of each initial-accumulator field
- IN_WIDTH, 8, chunk width on the input stream
- CSET_CYCLES, 1, number of cycles cset is held high per apply (>=1)
- Derived values:
  - CFG_WIDTH = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH (132 at defaults)
  - NUM_CHUNKS = ceil(CFG_WIDTH/IN_WIDTH) (17 at defaults)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  chunk valid
- in_ready  out  1  loader can accept a chunk
- in_data  in  IN_WIDTH  chunk payload
- in_last  in  1  marks final chunk of a configuration word
- cfg  out  CFG_WIDTH  to mac_cluster cfg: {initial3, initial2, initial1, initial0, mode}
- cset  out  1  to mac_cluster cset
- mac_en  out  1  to mac_cluster en
- loaded  out  1  high while a valid configuration is applied and the cluster is running
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (reset==0 at posedge clk): state=LOAD, count=0, shadow=0, cfg=0, cset=0, mac_en=0, loaded=0, frame_err=0. Reset takes effect from any state, including mid-load or mid-apply.
- A chunk is accepted when in_valid && in_ready at a posedge.
- in_ready is combinational from state: 1 in LOAD and RUN, 0 in APPLY.
- Chunk k is written to shadow[k*IN_WIDTH +: IN_WIDTH]. Bits at or above CFG_WIDTH in the last chunk are discarded.
- State LOAD (mac_en=0, cset=0):
  - Accept with count<NUM_CHUNKS-1 and !in_last: store chunk, count++.
  - Accept with count==NUM_CHUNKS-1 and in_last: store chunk; on the same edge cfg<=assembled word, cset<=1, count<=0, go APPLY.
  - Framing error: accept with in_last and count!=NUM_CHUNKS-1, or with count==NUM_CHUNKS-1 and !in_last.
    - frame_err=1 for exactly one cycle, count<=0.
    - Shadow contents are irrelevant; cfg is unchanged; stay in LOAD.
  - If NUM_CHUNKS==1, every chunk must carry in_last.
- State APPLY (mac_en=0, in_ready=0):
  - cfg is stable and cset=1 for exactly CSET_CYCLES cycles (internal counter).
  - On the final cset cycle: cset<=0, mac_en<=1, loaded<=1, go RUN.
- State RUN (mac_en=1, loaded=1, cset=0):
  - cfg is held constant.
  - An accepted chunk is treated as chunk 0 of a new word: stored, count<=1, mac_en<=0, loaded<=0, go LOAD. The same framing rules apply, so an in_last chunk when NUM_CHUNKS>1 raises frame_err.
- All outputs except in_ready are registered; there is no combinational path from inputs to cfg, cset, or mac_en.
- Latency: the first cset-high cycle is the cycle immediately after the last chunk is accepted. mac_en rises CSET_CYCLES cycles after that.
- in_data is ignored whenever in_valid==0 or in_ready==0.

Test Plan:
- Load mode=4'b0101, initial0..3=1,2,3,4 as 17 chunks, all 0x00 except chunk0=0x15, chunk4=0x20, chunk8=0x30, chunk12=0x40, in_last on chunk16 → cset high for exactly 1 cycle, starting the cycle after chunk16; cfg bits[3:0]=5, initial fields 1,2,3,4; mac_en=1 and loaded=1 one cycle later.
- Same load with in_valid toggled every other cycle → identical cfg; cset pulse follows the last accept by one cycle.
- in_last on chunk 5 → frame_err single pulse, cfg and cset unchanged; a following clean 17-chunk load of all 0xFF → cfg all ones (132 bits).
- While in RUN, start a new load → mac_en falls the cycle after the first accept; old cfg is held until the new APPLY; the new cfg is visible in the same cycle cset rises.
- reset=0 asserted at chunk 10 of a load, then released → all outputs zero; a subsequent full load is applied correctly with no residue from the aborted load.
- CSET_CYCLES=3 → cset high for exactly 3 consecutive cycles, in_ready=0 throughout, mac_en rises on the 4th cycle.
